// File: rtl/aes_round_sequencer_if.sv
// Request/response bundle between a block requester and the iterative AES engine.
// The requester drives start/key/data. The engine returns busy/done/ciphertext.
interface aes_round_sequencer_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [127:0] datain;
  logic         busy;
  logic         done;
  logic [127:0] dataout;

  modport master (output start, key_len, key, datain, input busy, done, dataout);
  modport slave  (input start, key_len, key, datain, output busy, done, dataout);
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryptor: one shared round datapath sequenced over Nr cycles,
// with round keys taken from a static schedule of the key latched at start.
module aes_round_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} fsm_t;
  typedef logic [14:0][127:0] rk_set_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = a;
    for (int i = 0; i < 6; i++) begin
      v = gf_mul(gf_mul(v, v), a);
    end
    v = gf_mul(v, v);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) begin
      o[127-8*j -: 8] = sbox(s[127-8*j -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Full key schedule for Nk words of key; always 15 round keys, extras unused.
  function automatic rk_set_t key_expand(input logic [255:0] k, input logic [3:0] nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rk_set_t     rks;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) begin
      w[i] = k[255-32*i -: 32];
    end
    for (int i = int'(nk); i < 60; i++) begin
      t = w[i-1];
      if ((i % int'(nk)) == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if ((nk == 4'd8) && ((i % int'(nk)) == 4)) begin
        t = sub_word(t);
      end else begin
        t = w[i-1];
      end
      w[i] = w[i-int'(nk)] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return rks;
  endfunction

  fsm_t         fsm_r;
  logic [3:0]   rc_r;
  logic [3:0]   nr_r;
  logic [1:0]   klen_r;
  logic [255:0] key_r;
  logic [127:0] blk_r;
  logic         busy_r;
  logic         done_r;
  logic [127:0] dataout_r;

  rk_set_t      rk128_s, rk192_s, rk256_s;
  logic [127:0] rk_s;
  logic [127:0] round_s;
  logic [127:0] final_s;

  // Static schedules of the latched key; they only change at block start.
  always_comb begin
    rk128_s = key_expand(key_r, 4'd4);
    rk192_s = key_expand(key_r, 4'd6);
    rk256_s = key_expand(key_r, 4'd8);
  end

  // Round-key mux: schedule of the latched key length, slot selected by rc.
  always_comb begin
    rk_s = 128'h0;
    case (klen_r)
      2'b01:   rk_s = rk192_s[rc_r];
      2'b10:   rk_s = rk256_s[rc_r];
      default: rk_s = rk128_s[rc_r];
    endcase
  end

  // Shared round datapath: full middle round and the MixColumns-free last round.
  always_comb begin
    round_s = mix_columns(shift_rows(sub_bytes(blk_r))) ^ rk_s;
    final_s = shift_rows(sub_bytes(blk_r)) ^ rk_s;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r     <= IDLE;
      rc_r      <= 4'd0;
      nr_r      <= 4'd10;
      klen_r    <= 2'b00;
      key_r     <= 256'h0;
      blk_r     <= 128'h0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dataout_r <= 128'h0;
    end else begin
      done_r <= 1'b0;
      case (fsm_r)
        IDLE: begin
          rc_r <= 4'd0;
          if (bus.start) begin
            key_r  <= bus.key;
            rc_r   <= 4'd1;
            // rk[0] is the first four key words for every key length.
            blk_r  <= bus.datain ^ bus.key[255:128];
            busy_r <= 1'b1;
            fsm_r  <= ROUND;
            case (bus.key_len)
              2'b01:   begin klen_r <= 2'b01; nr_r <= 4'd12; end
              2'b10:   begin klen_r <= 2'b10; nr_r <= 4'd14; end
              default: begin klen_r <= 2'b00; nr_r <= 4'd10; end
            endcase
          end else begin
            busy_r <= 1'b0;
          end
        end
        ROUND: begin
          blk_r <= round_s;
          rc_r  <= rc_r + 4'd1;
          if (rc_r == (nr_r - 4'd1)) begin
            fsm_r <= FINAL;
          end else begin
            fsm_r <= ROUND;
          end
        end
        FINAL: begin
          dataout_r <= final_s;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          rc_r      <= 4'd0;
          fsm_r     <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          rc_r   <= 4'd0;
          fsm_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.dataout = dataout_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: byte-array AES reference plus a countdown
// transaction model, compared against the DUT outputs every cycle.
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_round_sequencer_if bus ();
  aes_round_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] sbox_t [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_of(input logic [1:0] kl);
    return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Straight textbook cipher on byte arrays.
  function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [1:0] kl,
                                           input logic [127:0] pt);
    int nk, nr;
    logic [31:0] w [0:59];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    nr = nr_of(kl);
    nk = nr - 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sbox_t[s[j]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = t[q+4*((c+q)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  // Transaction model: accept when idle, then count Nr cycles to done.
  int cnt_m;
  logic [127:0] res_m;
  logic [127:0] exp_dout;
  logic exp_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_m <= 0; exp_done <= 1'b0; exp_dout <= 128'h0; res_m <= 128'h0;
    end else begin
      exp_done <= 1'b0;
      if (cnt_m == 0) begin
        if (bus.start === 1'b1) begin
          res_m <= aes_ref(bus.key, bus.key_len, bus.datain);
          cnt_m <= nr_of(bus.key_len);
        end
      end else if (cnt_m == 1) begin
        cnt_m <= 0; exp_done <= 1'b1; exp_dout <= res_m;
      end else begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("busy", {127'b0, bus.busy}, {127'b0, cnt_m != 0});
    chk("done", {127'b0, bus.done}, {127'b0, exp_done});
    chk("dataout", bus.dataout, exp_dout);
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic start_block(input logic [255:0] k, input logic [1:0] kl,
                             input logic [127:0] pt, output int c0);
    @(negedge clk);
    bus.key = k; bus.key_len = kl; bus.datain = pt; bus.start = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
  endtask

  task automatic wait_done(input string nm, output int ok);
    ok = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1;
        return;
      end
    end
    total++; bad++;
    $display("FAIL %s: got no done within 64 cycles want done", nm);
  endtask

  task automatic run_vec(input string nm, input logic [255:0] k, input logic [1:0] kl,
                         input logic [127:0] exp, input int lat);
    int c0, ok;
    start_block(k, kl, PT, c0);
    @(negedge clk) bus.start = 1'b0;
    wait_done(nm, ok);
    if (ok == 1) begin
      chk({nm, "_latency"}, 128'(cyc - c0), 128'(lat));
      chk({nm, "_data"}, bus.dataout, exp);
    end
  endtask

  logic [255:0] bk [0:4];
  logic [1:0]   bkl [0:4];
  logic [127:0] bexp [0:4];

  initial begin
    logic [7:0] p, q, x;
    int c0, ok, snap, t_prev, t_now;
    p = 8'h01; q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    bus.start = 1'b0; bus.key = 256'h0; bus.key_len = 2'b00; bus.datain = 128'h0;

    chk("ref_sbox53", {120'b0, sbox_t[8'h53]}, 128'hed);
    chk("ref_c1", aes_ref(K1, 2'b00, PT), CT1);
    chk("ref_c2", aes_ref(K2, 2'b01, PT), CT2);
    chk("ref_c3", aes_ref(K3, 2'b10, PT), CT3);
    chk("ref_c1_len11", aes_ref(K1, 2'b11, PT), CT1);

    repeat (3) @(negedge clk);
    chk("reset_busy", {127'b0, bus.busy}, 128'h0);
    chk("reset_done", {127'b0, bus.done}, 128'h0);
    chk("reset_dataout", bus.dataout, 128'h0);
    rst = 1'b0;

    run_vec("c1", K1, 2'b00, CT1, 10);
    run_vec("c2", K2, 2'b01, CT2, 12);
    run_vec("c3", K3, 2'b10, CT3, 14);

    // Inputs churn and extra starts while busy.
    snap = done_cnt;
    start_block(K1, 2'b00, PT, c0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.datain  = {$urandom, $urandom, $urandom, $urandom};
      bus.key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.key_len = 2'($urandom_range(0, 3));
      bus.start   = 1'($urandom_range(0, 1));
    end
    @(negedge clk) bus.start = 1'b0;
    wait_done("churn", ok);
    if (ok == 1) begin
      chk("churn_latency", 128'(cyc - c0), 128'd10);
      chk("churn_data", bus.dataout, CT1);
    end
    repeat (3) @(negedge clk);
    chk("churn_one_done", 128'(done_cnt - snap), 128'd1);

    // Back-to-back with start held high.
    bk[0] = K1; bkl[0] = 2'b00; bexp[0] = CT1;
    bk[1] = K3; bkl[1] = 2'b10; bexp[1] = CT3;
    bk[2] = K1; bkl[2] = 2'b11; bexp[2] = CT1;
    bk[3] = K3; bkl[3] = 2'b10; bexp[3] = CT3;
    bk[4] = K1; bkl[4] = 2'b00; bexp[4] = CT1;
    @(negedge clk);
    bus.key = bk[0]; bus.key_len = bkl[0]; bus.datain = PT; bus.start = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done("b2b", ok);
      if (ok == 0) break;
      t_now = cyc;
      chk("b2b_data", bus.dataout, bexp[k]);
      if (k > 0) chk("b2b_spacing", 128'(t_now - t_prev), 128'(nr_of(bkl[k]) + 1));
      t_prev = t_now;
      if (k < 4) begin
        bus.key = bk[k+1]; bus.key_len = bkl[k+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.key_len = 2'($urandom_range(0, 3));
      bus.datain  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk) bus.start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in the middle of an AES-256 block.
    start_block(K3, 2'b10, PT, c0);
    @(negedge clk) bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {127'b0, bus.busy}, 128'h0);
    chk("midrst_done", {127'b0, bus.done}, 128'h0);
    chk("midrst_dataout", bus.dataout, 128'h0);
    snap = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 128'(done_cnt - snap), 128'd0);
    run_vec("after_rst_c1", K1, 2'b00, CT1, 10);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
